// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 controllers (KSA and PRGA phases).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rc4_pkg;

    // PRGA controller states; one state per datapath micro-operation
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLR    = 4'd1,
        ST_INC_I  = 4'd2,
        ST_RD_SI  = 4'd3,
        ST_ST_SI  = 4'd4,
        ST_RD_SJ  = 4'd5,
        ST_ST_SJ  = 4'd6,
        ST_WR_SI  = 4'd7,
        ST_WR_SJ  = 4'd8,
        ST_RD_F   = 4'd9,
        ST_ST_F   = 4'd10,
        ST_WR_DEC = 4'd11,
        ST_INC_K  = 4'd12,
        ST_CHECK  = 4'd13,
        ST_DONE   = 4'd14
    } prga_state_t;

    // S memory address mux selects
    localparam logic [1:0] SEL_ADDR_I   = 2'b00;
    localparam logic [1:0] SEL_ADDR_J   = 2'b01;
    localparam logic [1:0] SEL_ADDR_SUM = 2'b10;

    // S memory write data mux selects
    localparam logic SEL_DATA_SI = 1'b0;
    localparam logic SEL_DATA_SJ = 1'b1;

    // Message length in bytes
    localparam int MSG_LEN = 32;

endpackage

// File: rtl/rd_wait_timer.sv
// Read-wait timer: counts the cycles a read address has been held in a wait state.
// Latency: expired rises in the RD_WAIT-th consecutive cycle of active.
// Backpressure: none; active is a level from the owning FSM, counter clears when it drops.
module rd_wait_timer #(
    parameter int RD_WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expired
);

    localparam int CW = ($clog2(RD_WAIT) < 1) ? 1 : $clog2(RD_WAIT);
    localparam logic [CW-1:0] LAST = CW'(RD_WAIT - 1);

    logic [CW-1:0] cnt;

    // Terminal count reached while the FSM is still waiting
    assign expired = active && (cnt == LAST);

    // Count while waiting; zero at entry and cleared on the exit cycle so it never passes LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (active && !expired) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/prga_controller.sv
// RC4 PRGA sequencer: drives datapath enables/selects over MSG_LEN bytes, k5 ends the loop.
// Latency: start->done = 1 + MSG_LEN*(12+3*(RD_WAIT-1)) + 1 cycles; outputs Moore-decoded.
// Backpressure: start honoured only while rdy; PRGA_ABORT_EN adds abort/aborted (stop at next CHECK).
module prga_controller
    import rc4_pkg::*;
#(
    parameter int RD_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       k5,
`ifdef PRGA_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic       rdy,
    output logic       done,
    output logic       dp_clr,
    output logic [1:0] sel_addr_s_mem,
    output logic       sel_data_s_mem,
    output logic       inc_i,
    output logic       store_j,
    output logic       store_s_i,
    output logic       store_s_j,
    output logic       store_f,
    output logic       inc_k,
    output logic       store_enc_k,
    output logic       s_wren,
    output logic       dec_wren
);

    prga_state_t state, state_nxt;
    logic        in_wait;
    logic        rd_expired;
    logic        abort_take;

    assign in_wait = (state == ST_RD_SI) || (state == ST_RD_SJ) || (state == ST_RD_F);

    rd_wait_timer #(.RD_WAIT(RD_WAIT)) u_rd_wait (
        .clk     (clk),
        .rst     (rst),
        .active  (in_wait),
        .expired (rd_expired)
    );

`ifdef PRGA_ABORT_EN
    logic abort_q;

    // Sticky abort request: armed only while running, re-armed clean on every new run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) abort_q <= 1'b0;
        end else if (abort) begin
            abort_q <= 1'b1;
        end
    end

    assign abort_take = abort_q;
    assign aborted    = (state == ST_CHECK) && abort_q;
`else
    assign abort_take = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: fixed micro-op order; read states hold until the wait timer expires
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_CLR;
            ST_CLR:    state_nxt = ST_INC_I;
            ST_INC_I:  state_nxt = ST_RD_SI;
            ST_RD_SI:  if (rd_expired) state_nxt = ST_ST_SI;
            ST_ST_SI:  state_nxt = ST_RD_SJ;
            ST_RD_SJ:  if (rd_expired) state_nxt = ST_ST_SJ;
            ST_ST_SJ:  state_nxt = ST_WR_SI;
            ST_WR_SI:  state_nxt = ST_WR_SJ;
            ST_WR_SJ:  state_nxt = ST_RD_F;
            ST_RD_F:   if (rd_expired) state_nxt = ST_ST_F;
            ST_ST_F:   state_nxt = ST_WR_DEC;
            ST_WR_DEC: state_nxt = ST_INC_K;
            ST_INC_K:  state_nxt = ST_CHECK;
            // k updates the cycle after INC_K, so k5 is only trustworthy here
            ST_CHECK:  begin
                if (abort_take)  state_nxt = ST_IDLE;
                else if (k5)     state_nxt = ST_DONE;
                else             state_nxt = ST_INC_I;
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Moore output decode; i==j swap needs no special case since the S[j] write lands last
    always_comb begin
        rdy            = 1'b0;
        done           = 1'b0;
        dp_clr         = 1'b0;
        sel_addr_s_mem = SEL_ADDR_I;
        sel_data_s_mem = SEL_DATA_SI;
        inc_i          = 1'b0;
        store_j        = 1'b0;
        store_s_i      = 1'b0;
        store_s_j      = 1'b0;
        store_f        = 1'b0;
        inc_k          = 1'b0;
        store_enc_k    = 1'b0;
        s_wren         = 1'b0;
        dec_wren       = 1'b0;
        unique case (state)
            ST_IDLE:   rdy = 1'b1;
            ST_CLR:    dp_clr = 1'b1;
            ST_INC_I:  inc_i = 1'b1;
            ST_RD_SI:  sel_addr_s_mem = SEL_ADDR_I;
            ST_ST_SI:  begin
                sel_addr_s_mem = SEL_ADDR_I;
                store_s_i      = 1'b1;
                store_j        = 1'b1;
            end
            ST_RD_SJ:  sel_addr_s_mem = SEL_ADDR_J;
            ST_ST_SJ:  begin
                sel_addr_s_mem = SEL_ADDR_J;
                store_s_j      = 1'b1;
            end
            ST_WR_SI:  begin
                sel_addr_s_mem = SEL_ADDR_I;
                sel_data_s_mem = SEL_DATA_SJ;
                s_wren         = 1'b1;
            end
            ST_WR_SJ:  begin
                sel_addr_s_mem = SEL_ADDR_J;
                sel_data_s_mem = SEL_DATA_SI;
                s_wren         = 1'b1;
            end
            ST_RD_F:   sel_addr_s_mem = SEL_ADDR_SUM;
            ST_ST_F:   begin
                sel_addr_s_mem = SEL_ADDR_SUM;
                store_f        = 1'b1;
                store_enc_k    = 1'b1;
            end
            ST_WR_DEC: dec_wren = 1'b1;
            ST_INC_K:  inc_k = 1'b1;
            ST_CHECK:  ;
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_prga_controller.sv
// Bench for prga_controller: two instances (RD_WAIT=1 and 3) each with a datapath/RAM model;
// decrypted bytes are compared with a software RC4 PRGA computed from the loaded S and enc.
module tb_prga_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b0;
    always #5 clk = ~clk;

    logic       start [2];
    logic       k5 [2];
    logic       rdy [2];
    logic       done [2];
    logic       dp_clr [2];
    logic [1:0] sel_addr [2];
    logic       sel_data [2];
    logic       inc_i [2];
    logic       store_j [2];
    logic       store_s_i [2];
    logic       store_s_j [2];
    logic       store_f [2];
    logic       inc_k [2];
    logic       store_enc_k [2];
    logic       s_wren [2];
    logic       dec_wren [2];
`ifdef PRGA_ABORT_EN
    logic       abort [2];
    logic       aborted [2];
`endif

    logic [7:0] init_s [256];
    logic [7:0] init_enc [32];
    logic [7:0] exp_dec [32];

    int n_tests = 0;
    int n_fail  = 0;

    // results of the last drive_run
    int r_done_cyc, r_done_cnt, r_ab_cyc, r_ab_cnt, r_s_cnt, r_d_cnt, r_seq_err;
    int r_post_rst_wren;
    logic r_rdy_after, r_rst_idle_ok;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RDW = (g == 0) ? 1 : 3;

        prga_controller #(.RD_WAIT(RDW)) dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start[g]),
            .k5             (k5[g]),
`ifdef PRGA_ABORT_EN
            .abort          (abort[g]),
            .aborted        (aborted[g]),
`endif
            .rdy            (rdy[g]),
            .done           (done[g]),
            .dp_clr         (dp_clr[g]),
            .sel_addr_s_mem (sel_addr[g]),
            .sel_data_s_mem (sel_data[g]),
            .inc_i          (inc_i[g]),
            .store_j        (store_j[g]),
            .store_s_i      (store_s_i[g]),
            .store_s_j      (store_s_j[g]),
            .store_f        (store_f[g]),
            .inc_k          (inc_k[g]),
            .store_enc_k    (store_enc_k[g]),
            .s_wren         (s_wren[g]),
            .dec_wren       (dec_wren[g])
        );

        // datapath registers and RAMs; S RAM read latency equals RDW
        logic [7:0] mi, mj, msi, msj, mf, mek, raddr, q;
        logic [5:0] mk;
        logic [7:0] smem [256];
        logic [7:0] decm [32];
        logic [7:0] pipe [3];

        always_comb begin
            case (sel_addr[g])
                2'b00:   raddr = mi;
                2'b01:   raddr = mj;
                default: raddr = 8'(msi + msj);
            endcase
        end
        assign q     = pipe[RDW-1];
        assign k5[g] = mk[5];

        always @(posedge clk) begin
            pipe[0] <= smem[raddr];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            if (load) begin
                for (int x = 0; x < 256; x++) smem[x] <= init_s[x];
                for (int x = 0; x < 32; x++)  decm[x] <= 8'h00;
            end else begin
                if (s_wren[g])   smem[raddr] <= sel_data[g] ? msj : msi;
                if (dec_wren[g]) decm[mk[4:0]] <= mf ^ mek;
            end
            if (dp_clr[g]) begin
                mi <= 8'd0; mj <= 8'd0; msi <= 8'd0; msj <= 8'd0;
                mf <= 8'd0; mek <= 8'd0; mk <= 6'd0;
            end else begin
                if (inc_i[g])       mi  <= mi + 8'd1;
                if (store_j[g])     mj  <= mj + q;
                if (store_s_i[g])   msi <= q;
                if (store_s_j[g])   msj <= q;
                if (store_f[g])     mf  <= q;
                if (store_enc_k[g]) mek <= init_enc[mk[4:0]];
                if (inc_k[g])       mk  <= mk + 6'd1;
            end
        end
    end

    function automatic int rdw(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int exp_done_cyc(input int g);
        return 1 + 32 * (12 + 3 * (rdw(g) - 1)) + 1;
    endfunction

    function automatic logic [7:0] dec_of(input int g, input int x);
        return (g == 0) ? g_dut[0].decm[x] : g_dut[1].decm[x];
    endfunction

    function automatic logic any_en(input int g);
        return dp_clr[g] | inc_i[g] | store_j[g] | store_s_i[g] | store_s_j[g] | store_f[g]
             | inc_k[g] | store_enc_k[g] | s_wren[g] | dec_wren[g] | done[g]
             | sel_data[g] | (|sel_addr[g]);
    endfunction

    // Plain software RC4 PRGA over the loaded S, xor'd with enc
    task automatic compute_ref();
        logic [7:0] s [256];
        logic [7:0] i, j, t;
        for (int x = 0; x < 256; x++) s[x] = init_s[x];
        i = 8'd0;
        j = 8'd0;
        for (int n = 0; n < 32; n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            exp_dec[n] = s[8'(s[i] + s[j])] ^ init_enc[n];
        end
    endtask

    task automatic load_mem(input bit randomize_data);
        logic [7:0] t;
        int r;
        for (int x = 0; x < 256; x++) init_s[x] = 8'(x);
        for (int x = 0; x < 32; x++)  init_enc[x] = 8'h00;
        if (randomize_data) begin
            for (int x = 255; x > 0; x--) begin
                r = $urandom_range(x, 0);
                t = init_s[x]; init_s[x] = init_s[r]; init_s[r] = t;
            end
            for (int x = 0; x < 32; x++) init_enc[x] = 8'($urandom);
        end
        compute_ref();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    // Start instance g at cycle 0 and watch it for max_cyc cycles
    task automatic drive_run(input int g, input int max_cyc, input int ga, input int gb,
                             input int ab_cyc, input int rst_cyc);
        int last_inc;
        r_done_cyc = -1; r_done_cnt = 0; r_ab_cyc = -1; r_ab_cnt = 0;
        r_s_cnt = 0; r_d_cnt = 0; r_seq_err = 0; r_post_rst_wren = 0;
        r_rdy_after = 1'b0; r_rst_idle_ok = 1'b0;
        last_inc = -100;
        @(negedge clk);
        start[g] = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rst) rst = 1'b0;
            if (s_wren[g] && dec_wren[g]) r_seq_err++;
            if (s_wren[g]) begin
                if (r_s_cnt % 2 == 0) begin
                    if (sel_addr[g] !== 2'b00 || sel_data[g] !== 1'b1) r_seq_err++;
                end else begin
                    if (sel_addr[g] !== 2'b01 || sel_data[g] !== 1'b0) r_seq_err++;
                end
                r_s_cnt++;
            end
            if (dec_wren[g]) r_d_cnt++;
            if (rst_cyc > 0 && c > rst_cyc && (s_wren[g] || dec_wren[g])) r_post_rst_wren++;
            if (inc_i[g]) last_inc = c;
            if (store_s_i[g] !== store_j[g]) r_seq_err++;
            if (store_s_i[g] && c != last_inc + rdw(g) + 1) r_seq_err++;
            if (done[g]) begin
                if (r_done_cyc < 0) r_done_cyc = c;
                r_done_cnt++;
            end
            if (r_done_cyc >= 0 && c == r_done_cyc + 1) r_rdy_after = rdy[g];
`ifdef PRGA_ABORT_EN
            if (aborted[g]) begin
                if (r_ab_cyc < 0) r_ab_cyc = c;
                r_ab_cnt++;
            end
            if (r_ab_cyc >= 0 && c == r_ab_cyc + 1) r_rdy_after = rdy[g];
            abort[g] = (c == ab_cyc);
`endif
            start[g] = (c == ga) || (c == gb);
            if (c == rst_cyc) begin
                #2 rst = 1'b1;
                #1 r_rst_idle_ok = rdy[g] && !any_en(g);
            end
        end
        start[g] = 1'b0;
    endtask

    task automatic check_full_run(input int g, input string tag);
        int bad;
        n_tests++;
        if (r_done_cyc !== exp_done_cyc(g)) begin
            n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, r_done_cyc, exp_done_cyc(g));
        end
        n_tests++;
        if (r_done_cnt !== 1) begin
            n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", tag, r_done_cnt);
        end
        n_tests++;
        if (r_rdy_after !== 1'b1) begin
            n_fail++; $display("FAIL %s rdy_after_done: got %b expected 1", tag, r_rdy_after);
        end
        n_tests++;
        if (r_s_cnt !== 64) begin
            n_fail++; $display("FAIL %s s_wren_count: got %0d expected 64", tag, r_s_cnt);
        end
        n_tests++;
        if (r_d_cnt !== 32) begin
            n_fail++; $display("FAIL %s dec_wren_count: got %0d expected 32", tag, r_d_cnt);
        end
        n_tests++;
        if (r_seq_err !== 0) begin
            n_fail++; $display("FAIL %s sequencing_errors: got %0d expected 0", tag, r_seq_err);
        end
        bad = 0;
        for (int x = 0; x < 32; x++) begin
            n_tests++;
            if (dec_of(g, x) !== exp_dec[x]) begin
                n_fail++; bad++;
                if (bad <= 4)
                    $display("FAIL %s dec[%0d]: got %h expected %h", tag, x, dec_of(g, x), exp_dec[x]);
            end
        end
    endtask

    task automatic test_reset();
        int en_cnt;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) start[g] = 1'b0;
`ifdef PRGA_ABORT_EN
        for (int g = 0; g < 2; g++) abort[g] = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_tests++;
            if (rdy[g] !== 1'b1 || any_en(g) !== 1'b0) begin
                n_fail++; $display("FAIL reset_outputs[%0d]: rdy=%b any_en=%b expected rdy=1 any_en=0", g, rdy[g], any_en(g));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        en_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) if (any_en(g) || !rdy[g]) en_cnt++;
        end
        n_tests++;
        if (en_cnt !== 0) begin
            n_fail++; $display("FAIL idle_no_enables: got %0d active cycles expected 0", en_cnt);
        end
    endtask

    task automatic test_full_rdwait1();
        load_mem(1'b0);
        drive_run(0, 400, -1, -1, -1, -1);
        check_full_run(0, "identity_rw1");
    endtask

    task automatic test_full_rdwait3();
        load_mem(1'b0);
        drive_run(1, 600, -1, -1, -1, -1);
        check_full_run(1, "identity_rw3");
    endtask

    task automatic test_start_ignored();
        load_mem(1'b0);
        drive_run(0, 400, 50, 200, -1, -1);
        check_full_run(0, "start_ignored");
    endtask

    task automatic test_random_data();
        int ga, gb;
        for (int g = 0; g < 2; g++) begin
            load_mem(1'b1);
            ga = $urandom_range(300, 3);
            gb = $urandom_range(380, 3);
            drive_run(g, (g == 0) ? 400 : 600, ga, gb, -1, -1);
            check_full_run(g, (g == 0) ? "random_rw1" : "random_rw3");
        end
    endtask

    task automatic test_reset_midrun();
        load_mem(1'b0);
        drive_run(0, 200, -1, -1, -1, 150);
        n_tests++;
        if (r_rst_idle_ok !== 1'b1) begin
            n_fail++; $display("FAIL midrun_reset_idle: got %b expected 1", r_rst_idle_ok);
        end
        n_tests++;
        if (r_post_rst_wren !== 0) begin
            n_fail++; $display("FAIL midrun_reset_wren: got %0d expected 0", r_post_rst_wren);
        end
        n_tests++;
        if (r_done_cnt !== 0 || rdy[0] !== 1'b1) begin
            n_fail++; $display("FAIL midrun_reset_state: done=%0d rdy=%b expected done=0 rdy=1", r_done_cnt, rdy[0]);
        end
        load_mem(1'b0);
        drive_run(0, 400, -1, -1, -1, -1);
        check_full_run(0, "rerun_after_reset");
    endtask

`ifdef PRGA_ABORT_EN
    task automatic test_abort();
        load_mem(1'b0);
        drive_run(0, 420, -1, -1, 40, -1);
        n_tests++;
        if (r_ab_cyc !== 49 || r_ab_cnt !== 1) begin
            n_fail++; $display("FAIL abort_pulse: cycle=%0d count=%0d expected cycle=49 count=1", r_ab_cyc, r_ab_cnt);
        end
        n_tests++;
        if (r_done_cnt !== 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d expected 0", r_done_cnt);
        end
        n_tests++;
        if (r_d_cnt !== 4) begin
            n_fail++; $display("FAIL abort_dec_wren: got %0d expected 4", r_d_cnt);
        end
        n_tests++;
        if (r_rdy_after !== 1'b1) begin
            n_fail++; $display("FAIL abort_rdy: got %b expected 1", r_rdy_after);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_rdwait1();
        test_full_rdwait3();
        test_start_ignored();
        test_random_data();
        test_reset_midrun();
`ifdef PRGA_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
